// File: rtl/pg_ctrl_pkg.sv
// pg_ctrl_pkg: shared state encoding and default counter width for the activity controller
package pg_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {ACTIVE = 2'd0, REQ_OFF = 2'd1, OFF = 2'd2, REQ_ON = 2'd3} state_t;
endpackage

// File: rtl/pg_activity_ctrl_if.sv
// pg_activity_ctrl_if: activity, sequencer and upstream back-pressure signals of the controller
interface pg_activity_ctrl_if import pg_ctrl_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic [CNT_W-1:0] idle_threshold;
  logic [CNT_W-1:0] sleep_cnt;
  logic force_on;
  logic busy;
  logic src_valid;
  logic status;
  logic en;
  logic hold;
  modport master(input idle_threshold, force_on, busy, src_valid, status, output en, hold, sleep_cnt);
  modport slave(output idle_threshold, force_on, busy, src_valid, status, input en, hold, sleep_cnt);
endinterface

// File: rtl/pg_sat_counter.sv
// pg_sat_counter: counter with synchronous clear and increment that sticks at all-ones
module pg_sat_counter #(parameter int W = 16) (
  input  logic         ck,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge ck or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pg_activity_ctrl.sv
// pg_activity_ctrl: idle-driven power-down request and wake/back-pressure control for the power-gating sequencer
module pg_activity_ctrl import pg_ctrl_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
  input logic                ck,
  input logic                rst,
  pg_activity_ctrl_if.master bus
);
  state_t st, nxt;
  logic wake_pend, idle, wake, hit;
  logic [CNT_W-1:0] idle_cnt;
  assign idle = !bus.busy && !bus.src_valid && !bus.force_on;
  assign wake = bus.src_valid || bus.force_on;
  // >= rather than == so a threshold lowered mid-count still fires on the next compare
  assign hit  = idle && bus.idle_threshold != '0 && idle_cnt >= bus.idle_threshold - 1'b1;
  always_comb begin
    nxt = st;
    case (st)
      ACTIVE:  nxt = hit ? REQ_OFF : ACTIVE;
      REQ_OFF: nxt = bus.status ? REQ_OFF : (wake_pend || wake) ? REQ_ON : OFF;
      OFF:     nxt = wake ? REQ_ON : OFF;
      default: nxt = bus.status ? ACTIVE : REQ_ON;
    endcase
  end
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      st        <= ACTIVE;
      bus.en    <= 1'b1;
      bus.hold  <= 1'b0;
      wake_pend <= 1'b0;
    end else begin
      st        <= nxt;
      bus.en    <= nxt == ACTIVE || nxt == REQ_ON;
      bus.hold  <= nxt != ACTIVE;
      wake_pend <= st == REQ_OFF ? wake_pend || wake : (st == REQ_ON && bus.status) ? 1'b0 : wake_pend;
    end
  pg_sat_counter #(.W(CNT_W)) u_idle (
    .ck  (ck),
    .rst (rst),
    .clr ((st == ACTIVE && (!idle || hit)) || (st == REQ_ON && bus.status)),
    .inc (st == ACTIVE && idle),
    .q   (idle_cnt)
  );
  pg_sat_counter #(.W(CNT_W)) u_sleep (
    .ck  (ck),
    .rst (rst),
    .clr (1'b0),
    .inc (st == REQ_OFF && !bus.status),
    .q   (bus.sleep_cnt)
  );
endmodule
